// File: rtl/md_sched.sv
// md_sched: multiply/divide scheduler between the E stage and an iterative
// mul/div unit. It issues requests, stalls the front end while HI/LO is busy,
// and generates the HI/LO write enables for unit results and mthi/mtlo.
// Optional feature macro: MD_CANCEL_EN. When it is defined, a flush (Req)
// during an operation moves to DRAIN, where the unit result is waited for and
// then discarded.
module md_sched #(
  parameter int unsigned TIMEOUT_CYCLES = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       E_valid,
  input  logic [3:0] E_MDCtrl,
  input  logic       Req,
  input  logic       u_in_ready,
  input  logic       u_out_valid,
  output logic       u_in_valid,
  output logic [1:0] u_in_op,
  output logic       u_in_sign,
  output logic       u_out_ready,
  output logic       stall,
  output logic       busy,
  output logic [1:0] hilo_we,
  output logic       hilo_src,
  output logic       err
);

  // One spare bit above what TIMEOUT_CYCLES needs, so the saturating counter
  // always passes through the timeout value before it sticks.
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1) + 1;
  localparam logic [CntW-1:0] CntTimeout = CntW'(TIMEOUT_CYCLES);
  localparam logic [CntW-1:0] CntMax = '1;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StBusy  = 2'd1;
  localparam logic [1:0] StDrain = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;

  logic is_idle;
  logic is_active;
  logic is_md_op;
  logic is_hilo_op;
  logic is_mthi;
  logic is_mtlo;
  logic start;
  logic done;
  logic cancel;
  logic result_we;
  logic mt_we;

  // Opcode decode and the qualified events built from it.
  always_comb begin
    is_idle    = (state_q == StIdle);
    is_active  = ~is_idle;
    is_md_op   = (E_MDCtrl[3:2] == 2'b00);
    is_hilo_op = ~E_MDCtrl[3];
    is_mthi    = (E_MDCtrl == 4'b0110);
    is_mtlo    = (E_MDCtrl == 4'b0111);
    start      = is_idle & E_valid & is_md_op & ~Req;
    done       = is_active & u_out_valid;
`ifdef MD_CANCEL_EN
    cancel     = (state_q == StBusy) & Req;
`else
    cancel     = 1'b0;
`endif
    // A result arriving together with a flush is dropped when cancel is on.
    result_we  = (state_q == StBusy) & u_out_valid & ~cancel;
    mt_we      = is_idle & E_valid & ~Req & (is_mthi | is_mtlo);
  end

  // Unit request, HI/LO write control and pipeline stall outputs.
  always_comb begin
    u_in_valid  = start;
    u_in_op     = 2'b00;
    u_in_sign   = 1'b0;
    if (start) begin
      u_in_op   = E_MDCtrl[1] ? 2'b10 : 2'b01;
      u_in_sign = ~E_MDCtrl[0];
    end
    u_out_ready = is_active;
    busy        = is_active;
    hilo_we     = 2'b00;
    hilo_src    = 1'b0;
    if (result_we) begin
      hilo_we   = 2'b11;
    end else if (mt_we) begin
      hilo_we   = {is_mthi, is_mtlo};
      hilo_src  = 1'b1;
    end
    // The completing cycle releases the stall so a waiting mfhi/mflo reads
    // the freshly written HI/LO one cycle later.
    stall       = (start & ~u_in_ready) | (is_active & E_valid & is_hilo_op & ~done);
    err         = err_q;
  end

  // Next state: issue, completion, and optional flush drain.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start && u_in_ready) begin
          state_d = StBusy;
        end
      end
      StBusy: begin
        if (u_out_valid) begin
          state_d = StIdle;
        end else if (cancel) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (u_out_valid) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Wait-cycle counter and sticky timeout flag.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d == StIdle) begin
      cnt_d = '0;
    end else if (is_active && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + CntW'(1);
    end
    err_d = err_q | (is_active & (cnt_d == CntTimeout));
  end

  // State registers, cleared asynchronously by the active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

endmodule
